// File: rtl/fpga_3x3_fabric.sv
// 3x3 serially configured logic fabric. Nine cells, each a 3-input LUT
// with an optional output flip-flop, programmed through an 81-bit shift
// chain. Data moves strictly from column 0 (fed by fab_in) to column 2
// (driving fab_out), so no combinational loop can be configured.
// Cell k = col*3 + row owns chain bits [9k+8:9k]: [9k+7:9k] is the LUT
// truth table, bit 9k+8 selects the registered output.
module fpga_3x3_fabric (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_en,
  input  logic       cfg_din,
  output logic       cfg_dout,
  output logic       cfg_done,
  input  logic [2:0] fab_in,
  output logic [2:0] fab_out
);
  localparam int CELL_BITS = 9;
  localparam int CFG_BITS  = 81;

  logic [CFG_BITS-1:0] r_chain;
  logic [6:0]          r_cnt;
  logic [8:0]          r_ff;

  // LUT results and cell outputs per column, bit index = row
  logic [2:0] w_lut0, w_lut1, w_lut2;
  logic [2:0] w_col0, w_col1, w_col2;

  // Per-row LUT lookup and output mux for each of the three columns
  for (genvar g_r = 0; g_r < 3; g_r++) begin : g_row
    logic [7:0] w_t0, w_t1, w_t2;
    assign w_t0 = r_chain[CELL_BITS*g_r +: 8];
    assign w_t1 = r_chain[CELL_BITS*(3+g_r) +: 8];
    assign w_t2 = r_chain[CELL_BITS*(6+g_r) +: 8];

    assign w_lut0[g_r] = w_t0[fab_in];
    assign w_lut1[g_r] = w_t1[w_col0];
    assign w_lut2[g_r] = w_t2[w_col1];

    assign w_col0[g_r] = r_chain[CELL_BITS*g_r+8]     ? r_ff[g_r]   : w_lut0[g_r];
    assign w_col1[g_r] = r_chain[CELL_BITS*(3+g_r)+8] ? r_ff[3+g_r] : w_lut1[g_r];
    assign w_col2[g_r] = r_chain[CELL_BITS*(6+g_r)+8] ? r_ff[6+g_r] : w_lut2[g_r];
  end

  // Chain is complete once exactly CFG_BITS bits have gone in since reset
  assign cfg_done = (r_cnt == 7'(CFG_BITS));
  assign cfg_dout = r_chain[CFG_BITS-1];
  assign fab_out  = cfg_done ? w_col2 : 3'b000;

  // Configuration shift chain and saturating bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_cnt   <= '0;
    end else if (cfg_en) begin
      r_chain <= {r_chain[CFG_BITS-2:0], cfg_din};
      if (!cfg_done) r_cnt <= r_cnt + 7'd1;
    end
  end

  // Cell flip-flops capture their LUT every user cycle and freeze while shifting;
  // a cell only exposes its FF when its register-select bit is set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ff <= '0;
    end else if (!cfg_en) begin
      r_ff <= {w_lut2, w_lut1, w_lut0};
    end
  end
endmodule

// File: tb/tb_fpga_3x3_fabric.sv
// Self-checking bench for fpga_3x3_fabric: directed vector tables, hand
// sequences for pipeline latency and chain replay, and randomized traffic
// checked against a queue-based behavioural model of the fabric.
module tb_fpga_3x3_fabric;
  logic       clk = 1'b0;
  logic       rst_n, cfg_en, cfg_din;
  logic       cfg_dout, cfg_done;
  logic [2:0] fab_in, fab_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         grp;
    logic [2:0] in_v;
    logic [2:0] exp_v;
  } vec_t;
  vec_t vecs[13];

  logic [0:0] exp_q[$];

  // behavioural model: last 81 bits sent (front = oldest = chain bit 80)
  bit         m_q[$];
  int         m_cnt;
  logic [8:0] m_ff;

  fpga_3x3_fabric dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .cfg_done(cfg_done), .fab_in(fab_in), .fab_out(fab_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] m_t(input int k);
    logic [7:0] t;
    for (int b = 0; b < 8; b++) t[b] = m_q[80 - (9*k + b)];
    return t;
  endfunction

  function automatic logic m_reg(input int k);
    return m_q[80 - (9*k + 8)];
  endfunction

  function automatic void m_eval(input logic [2:0] in_v, output logic [8:0] lut, output logic [8:0] outv);
    logic [2:0] sel, nxt;
    logic [7:0] t;
    int k;
    sel = in_v; lut = '0; outv = '0;
    for (int c = 0; c < 3; c++) begin
      nxt = '0;
      for (int r = 0; r < 3; r++) begin
        k = 3*c + r;
        t = m_t(k);
        lut[k]  = ((t >> sel) & 8'd1) != 8'd0;
        outv[k] = m_reg(k) ? m_ff[k] : lut[k];
        nxt[r]  = outv[k];
      end
      sel = nxt;
    end
  endfunction

  function automatic logic [2:0] m_fab_out();
    logic [8:0] l, o;
    m_eval(fab_in, l, o);
    return (m_cnt == 81) ? o[8:6] : 3'b000;
  endfunction

  function automatic void model_clock();
    logic [8:0] l, o;
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < 81; i++) m_q.push_back(1'b0);
      m_cnt = 0;
      m_ff  = '0;
    end else if (cfg_en) begin
      m_q.push_back(cfg_din);
      void'(m_q.pop_front());
      if (m_cnt < 81) m_cnt++;
    end else begin
      m_eval(fab_in, l, o);
      m_ff = l;
    end
  endfunction

  // driver tasks
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1; cfg_din = b;
    tick();
    cfg_en = 1'b0;
  endtask

  task automatic load(input logic [80:0] p);
    for (int i = 80; i >= 0; i--) shift_bit(p[i]);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_out"},  8'(fab_out),  8'(m_fab_out()));
    check({name, "_done"}, 8'(cfg_done), 8'(m_cnt == 81));
    check({name, "_dout"}, 8'(cfg_dout), 8'(m_q[0]));
  endtask

  function automatic logic [80:0] set_cell(input logic [80:0] p, input int k, input logic [7:0] t, input logic reg_b);
    logic [80:0] q;
    q = p;
    for (int b = 0; b < 8; b++) q[9*k + b] = t[b];
    q[9*k + 8] = reg_b;
    return q;
  endfunction

  function automatic logic [80:0] wire_cfg(input logic reg_b);
    logic [80:0] p;
    logic [7:0]  t;
    p = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        t = (r == 0) ? 8'hAA : (r == 1) ? 8'hCC : 8'hF0;
        p = set_cell(p, 3*c + r, t, reg_b);
      end
    return p;
  endfunction

  task automatic run_group(input int g, input string name);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].grp == g) begin
        fab_in = vecs[i].in_v;
        #1;
        check(name, 8'(fab_out), 8'(vecs[i].exp_v));
      end
    end
  endtask

  initial begin
    logic [80:0] p_wire, p_pipe, p_and, p_rnd;
    logic [95:0] tmp;

    // vector table: group 3 = wire-through, group 5 = AND3 chain
    for (int i = 0; i < 8; i++) vecs[i] = '{3, 3'(i), 3'(i)};
    vecs[8]  = '{5, 3'b111, 3'b001};
    vecs[9]  = '{5, 3'b011, 3'b000};
    vecs[10] = '{5, 3'b110, 3'b000};
    vecs[11] = '{5, 3'b101, 3'b000};
    vecs[12] = '{5, 3'b000, 3'b000};

    p_wire = wire_cfg(1'b0);
    p_pipe = wire_cfg(1'b1);
    p_and  = '0;
    p_and  = set_cell(p_and, 0, 8'h80, 1'b0);
    p_and  = set_cell(p_and, 3, 8'hAA, 1'b0);
    p_and  = set_cell(p_and, 6, 8'hAA, 1'b0);

    cfg_din = 1'b0; fab_in = 3'b101;

    // T1 reset
    do_reset();
    check("t1_fab_out", 8'(fab_out), 8'h0);
    check("t1_done",    8'(cfg_done), 8'h0);
    check("t1_dout",    8'(cfg_dout), 8'h0);

    // T2 partial load, completion
    for (int i = 80; i >= 1; i--) shift_bit(p_wire[i]);
    check("t2_done_80", 8'(cfg_done), 8'h0);
    check("t2_out_80",  8'(fab_out),  8'h0);
    shift_bit(p_wire[0]);
    check("t2_done_81", 8'(cfg_done), 8'h1);

    // T3 wire-through table
    run_group(3, "t3_wire");

    // mid-load reset discards partial chain and count
    do_reset();
    for (int i = 80; i >= 40; i--) shift_bit(p_wire[i]);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    fab_in = 3'b111; #1;
    check("t2_midrst_done", 8'(cfg_done), 8'h0);
    check("t2_midrst_out",  8'(fab_out),  8'h0);
    for (int i = 80; i >= 1; i--) shift_bit(p_wire[i]);
    check("t2_reload_80", 8'(cfg_done), 8'h0);
    shift_bit(p_wire[0]);
    check("t2_reload_81", 8'(cfg_done), 8'h1);
    check("t2_reload_out", 8'(fab_out), 8'h7);

    // T4 pipeline latency
    do_reset();
    fab_in = 3'b110;
    load(p_pipe);
    check("t4_clk0", 8'(fab_out), 8'h0);
    tick(); check("t4_clk1", 8'(fab_out), 8'h0);
    tick(); check("t4_clk2", 8'(fab_out), 8'h0);
    tick(); check("t4_clk3", 8'(fab_out), 8'h6);

    // T6 chain replay and FF hold while re-shifting the same pattern
    fab_in = 3'b001;
    for (int i = 80; i >= 0; i--) exp_q.push_back(p_pipe[i]);
    for (int i = 80; i >= 0; i--) begin
      check("t6_replay", 8'(cfg_dout), 8'(exp_q.pop_front()));
      shift_bit(p_pipe[i]);
    end
    check("t6_hold_done", 8'(cfg_done), 8'h1);
    check("t6_hold", 8'(fab_out), 8'h6);
    tick(); check("t6_after1", 8'(fab_out), 8'h6);
    tick(); check("t6_after2", 8'(fab_out), 8'h6);
    tick(); check("t6_after3", 8'(fab_out), 8'h1);

    // T5 AND3 logic table
    do_reset();
    load(p_and);
    run_group(5, "t5_and");

    // randomized traffic against the model
    for (int round = 0; round < 6; round++) begin
      do_reset();
      tmp   = {$urandom(), $urandom(), $urandom()};
      p_rnd = tmp[80:0];
      for (int i = 80; i >= 0; i--) begin
        if ($urandom_range(0, 7) == 0) begin
          fab_in = 3'($urandom_range(0, 7));
          tick();
        end
        shift_bit(p_rnd[i]);
      end
      check_model("rnd_loaded");
      for (int cyc = 0; cyc < 60; cyc++) begin
        fab_in  = 3'($urandom_range(0, 7));
        cfg_en  = ($urandom_range(0, 15) == 0);
        cfg_din = 1'($urandom_range(0, 1));
        rst_n   = ($urandom_range(0, 49) != 0);
        #1;
        check_model("rnd");
        tick();
        rst_n = 1'b1; cfg_en = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
